// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encodings, the
// per-register control bundle and the canned control patterns each stall type drives.
package pipe_stall_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    // Instruction word loaded into a pipeline register when a bubble is inserted.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IMISS = 2'd1,
        ST_DMISS = 2'd2,
        ST_MDU   = 2'd3
    } state_e;

    typedef struct packed {
        logic we_pc;
        logic we_ifid;
        logic we_idex;
        logic we_exmem;
        logic we_memwb;
        logic bubble_idex;
        logic bubble_memwb;
    } ctrl_t;

    localparam ctrl_t CTRL_FROZEN = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_FLOW   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    // Front end held, NOP into ID/EX; used for I-cache miss and load-use.
    localparam ctrl_t CTRL_FETCH  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // Everything up to EX/MEM held, NOP drains into MEM/WB.
    localparam ctrl_t CTRL_DMISS  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam ctrl_t CTRL_MDU    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX.
module pipe_stall_ctrl_hazard_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    output logic             load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_use_rs && (id_rs == ex_rd);
    assign rt_hit   = id_use_rt && (id_rt == ex_rd);
    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = ex_is_load && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: drives register write enables and
// bubbles, tracks cache/MDU waits, and provides a miss watchdog and stall counter.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 1023,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             icache_ready,
    input  logic             dcache_req,
    input  logic             dcache_ready,
    input  logic             mdu_start,
    input  logic             mdu_done,
    output logic             we_pc,
    output logic             we_ifid,
    output logic             we_idex,
    output logic             we_exmem,
    output logic             we_memwb,
    output logic             bubble_idex,
    output logic             bubble_memwb,
    output logic [1:0]       busy_state,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [15:0] WaitMax = 16'(WAIT_MAX);

    state_e            state_q, state_d;
    ctrl_t             ctrl;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              load_use;
    logic              dmiss;
    logic              mdu_wait;

    pipe_stall_ctrl_hazard_detect u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    assign dmiss    = dcache_req && !dcache_ready;
    assign mdu_wait = mdu_start && !mdu_done;

    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_FLOW;
        unique case (state_q)
            // IMISS re-runs the RUN priority each cycle, so a ready fetch falls straight
            // through to normal evaluation and a D-miss or MDU op preempts it.
            ST_RUN, ST_IMISS: begin
                if (dmiss) begin
                    ctrl    = CTRL_DMISS;
                    state_d = ST_DMISS;
                end else if (mdu_wait) begin
                    ctrl    = CTRL_MDU;
                    state_d = ST_MDU;
                end else if (!icache_ready) begin
                    ctrl    = CTRL_FETCH;
                    state_d = ST_IMISS;
                end else if (load_use) begin
                    ctrl    = CTRL_FETCH;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DMISS: begin
                if (dcache_ready) begin
                    state_d = ST_RUN;
                end else begin
                    ctrl = CTRL_DMISS;
                end
            end
            ST_MDU: begin
                if (dmiss) begin
                    ctrl    = CTRL_DMISS;
                    state_d = ST_DMISS;
                end else if (mdu_done) begin
                    state_d = ST_RUN;
                end else begin
                    ctrl = CTRL_MDU;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (reset) begin
            ctrl = CTRL_FROZEN;
        end
    end

    always_comb begin
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (state_q != ST_RUN && wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        err_d = err_q || (wait_cnt_d == WaitMax);
        if (!ctrl.we_pc && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State moves on the falling edge, in step with the pipeline registers.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            stall_q    <= stall_d;
        end
    end

    assign we_pc        = ctrl.we_pc;
    assign we_ifid      = ctrl.we_ifid;
    assign we_idex      = ctrl.we_idex;
    assign we_exmem     = ctrl.we_exmem;
    assign we_memwb     = ctrl.we_memwb;
    assign bubble_idex  = ctrl.bubble_idex;
    assign bubble_memwb = ctrl.bubble_memwb;
    assign busy_state   = state_q;
    assign err_timeout  = err_q;
    assign stall_cycles = stall_q;

endmodule
